// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants, state encoding and funct3 decode helpers for
// the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int ITERS = 32;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: shared 64-bit accumulator plus one shift-add (multiply)
// or restoring-subtract (divide) step per cycle.
//   load     : acc <= init, latch opnd (multiplicand / divisor) and mode
//   step     : advance one iteration
//   acc      : multiply -> 64-bit product; divide -> {remainder, quotient}
module muldiv_iter_core
  import muldiv_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic              div_mode,
  input  logic [2*XLEN-1:0] init,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc
);

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic              mode_q;

  logic [XLEN:0]     sum;
  logic [XLEN+1:0]   diff;
  logic [2*XLEN-1:0] mul_nxt, div_nxt;

  always_comb begin
    // Shift-add: multiplier bits sit in the low half and shift out as the
    // product (with its carry) shifts in from the top.
    sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_nxt = {sum, acc_q[XLEN-1:1]};
    // Restoring divide: the shifted partial remainder needs XLEN+1 bits;
    // borrow (diff MSB) means restore, otherwise keep difference, shift in 1.
    diff    = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, opnd_q};
    div_nxt = diff[XLEN+1] ? {acc_q[2*XLEN-2:0], 1'b0}
                           : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q  <= '0;
      opnd_q <= '0;
      mode_q <= 1'b0;
    end else if (load) begin
      acc_q  <= init;
      opnd_q <= opnd;
      mode_q <= div_mode;
    end else if (step) begin
      acc_q  <= mode_q ? div_nxt : mul_nxt;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execute unit.
//   clock, reset (sync, active-high)
//   start/funct3/operandA/operandB : request, accepted when ready=1
//   ready (IDLE), busy (CALC/FIX/DONE), done (1-cycle pulse), result (held)
// Optional: define MULDIV_FAST_MUL_EN for single-cycle combinational
// multiplies (IDLE->FIX->DONE); divides are unaffected.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operandA,
  input  logic [XLEN-1:0] operandB,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_t            state_q, state_d;
  logic [4:0]        cnt_q;
  logic [2:0]        f3_q;
  logic              neg_q, spec_q;
  logic [XLEN-1:0]   spec_val_q, result_q;

  logic              load, step, fast;
  logic              sa, sb, neg_a, neg_b, neg_d, div_zero, ovf, spec_hit;
  logic [XLEN-1:0]   ma, mb, spec_val, fix_val, qr;
  logic [2*XLEN-1:0] init, acc, prod;

  // Operand decode: magnitudes, special cases and final sign, all resolved
  // from the live inputs so they can be captured on the accepting edge.
  always_comb begin
    sa       = is_signed_a(funct3);
    sb       = is_signed_b(funct3);
    neg_a    = sa & operandA[XLEN-1];
    neg_b    = sb & operandB[XLEN-1];
    ma       = neg_a ? -operandA : operandA;
    mb       = neg_b ? -operandB : operandB;
    // Remainder follows the dividend; product/quotient negate on sign mismatch.
    neg_d    = (is_div(funct3) && funct3[1]) ? neg_a : (neg_a ^ neg_b);
    div_zero = is_div(funct3) && (operandB == '0);
    ovf      = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
               (operandA == 32'h8000_0000) && (operandB == 32'hFFFF_FFFF);
    spec_hit = div_zero || ovf;
    if (div_zero) spec_val = funct3[1] ? operandA : 32'hFFFF_FFFF;
    else          spec_val = funct3[1] ? 32'h0 : 32'h8000_0000;
`ifdef MULDIV_FAST_MUL_EN
    fast = !is_div(funct3);
    init = fast ? (64'(ma) * 64'(mb)) : {{XLEN{1'b0}}, ma};
`else
    fast = 1'b0;
    init = {{XLEN{1'b0}}, ma};
`endif
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        load    = 1'b1;
        state_d = (spec_hit || fast) ? FIX : CALC;
      end
      CALC: begin
        step = 1'b1;
        if (cnt_q == 5'(ITERS - 1)) state_d = FIX;
      end
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prod = neg_q ? -acc : acc;
    qr   = f3_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    if (spec_q)            fix_val = spec_val_q;
    else if (is_div(f3_q)) fix_val = neg_q ? -qr : qr;
    else if (f3_q == F3_MUL) fix_val = prod[XLEN-1:0];
    else                   fix_val = prod[2*XLEN-1:XLEN];
  end

  muldiv_iter_core u_core (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .div_mode (is_div(funct3)),
    .init     (init),
    .opnd     (mb),
    .acc      (acc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      f3_q       <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      result_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        cnt_q      <= '0;
        f3_q       <= funct3;
        neg_q      <= neg_d;
        spec_q     <= spec_hit;
        spec_val_q <= spec_val;
      end else if (step) begin
        cnt_q <= cnt_q + 5'd1;
      end
      if (state_q == FIX) result_q <= fix_val;
    end
  end

  assign ready  = (state_q == IDLE);
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  logic        clock = 1'b0;
  logic        reset, start;
  logic [2:0]  funct3;
  logic [31:0] operandA, operandB, result;
  logic        ready, busy, done;

  int checks = 0;
  int failures = 0;

  muldiv_unit dut (
    .clock(clock), .reset(reset), .start(start), .funct3(funct3),
    .operandA(operandA), .operandB(operandB),
    .ready(ready), .busy(busy), .done(done), .result(result)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic straight from the RV32M rules.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 2;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 2;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      4: return 32'(int'($urandom_range(0, 20)));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op; optionally pulse start at edge poke_at (counter = poke_at-1).
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int poke_at);
    logic [31:0] exp, got_res;
    int lat, n, dones, got_lat;
    logic rdy_bad;
    exp = model(f, a, b);
    lat = exp_lat(f, a, b);
    @(negedge clock);
    start = 1'b1; funct3 = f; operandA = a; operandB = b;
    @(posedge clock); #1;
    start = 1'b0; n = 1; dones = 0; got_lat = 0; got_res = '0; rdy_bad = 1'b0;
    operandA = $urandom; operandB = $urandom; funct3 = 3'($urandom);
    while (n <= lat + 2) begin
      if (done) begin
        dones++;
        if (got_lat == 0) begin got_lat = n; got_res = result; end
      end else if (got_lat == 0 && (ready || !busy)) rdy_bad = 1'b1;
      start = (n == poke_at);
      @(posedge clock); #1; n++;
    end
    start = 1'b0;
    chk({tag, ".lat"}, 64'(got_lat), 64'(lat));
    chk({tag, ".res"}, {32'b0, got_res}, {32'b0, exp});
    chk({tag, ".ndone"}, 64'(dones), 64'd1);
    chk({tag, ".busy"}, {63'b0, rdy_bad}, 64'd0);
    chk({tag, ".idle"}, {62'b0, ready, busy}, 64'd2);
  endtask

  initial begin
    int n, dones;
    logic [2:0] f;
    reset = 1'b1; start = 1'b0; funct3 = '0; operandA = '0; operandB = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst.state", {60'b0, ready, busy, done, 1'b0}, 64'b1000);
    chk("rst.result", {32'b0, result}, 64'd0);
    reset = 1'b0;

    run_op("mul",    3'd0, 32'd7,         32'hFFFF_FFFD, 0);
    chk("mul.val", {32'b0, result}, 64'hFFFF_FFEB);
    run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("divu",   3'd5, 32'd100, 32'd7, 0);
    run_op("remu",   3'd7, 32'd100, 32'd7, 0);
    run_op("div0",   3'd4, 32'd5, 32'd0, 0);
    run_op("remu0",  3'd7, 32'd5, 32'd0, 0);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    // start pulsed during CALC (counter=10) must be ignored
    run_op("poke",   3'd5, 32'd100, 32'd7, 11);
    run_op("pokem",  3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 11);

    // reset at counter=20 aborts the op
    @(negedge clock);
    start = 1'b1; funct3 = 3'd5; operandA = 32'd1000; operandB = 32'd3;
    @(posedge clock); #1;
    start = 1'b0; n = 1; dones = 0;
    while (n < 21) begin
      if (done) dones++;
      @(posedge clock); #1; n++;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("abort.state", {60'b0, ready, busy, done, 1'b0}, 64'b1000);
    chk("abort.result", {32'b0, result}, 64'd0);
    repeat (40) begin
      if (done) dones++;
      @(posedge clock); #1;
    end
    chk("abort.ndone", 64'(dones), 64'd0);
    run_op("mul34", 3'd0, 32'd3, 32'd4, 0);

    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom);
      run_op("rnd", f, pick(), pick(), ($urandom_range(0, 3) == 0) ? 5 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execute unit, directly downstream of the register file.
- Consumes the two register read operands plus funct3; produces a 32-bit result for the write-back mux (writeData path).
- Multi-cycle, start/done handshake; control holds the pipeline while busy is high.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
ITERS, 32, shift-add / restoring-divide iterations; must equal XLEN.

Ports:
clock  input  1  single clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high; sampled on the rising edge of clock.
start  input  1  request; accepted only when ready=1.
funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
operandA  input  32  rs1 value (readData1).
operandB  input  32  rs2 value (readData2).
ready  output  1  high only in IDLE.
busy  output  1  high in CALC, FIX and DONE.
done  output  1  one-cycle pulse; result is valid in the same cycle.
result  output  32  final value; held until the next accepted start.

Behaviour:
- Reset values: state=IDLE, ready=1, busy=0, done=0, result=0, counter=0. Reset mid-operation aborts the operation; no done is produced.
- States:
  - IDLE: on start, capture funct3, operandA and operandB.
    - Normal case: go to CALC with counter=0.
    - Divide special cases (below): go straight to FIX.
  - CALC: one iteration per cycle; counter increments; at counter=31 go to FIX.
  - FIX: apply sign correction, select the high/low half or quotient/remainder, load result; go to DONE.
  - DONE: done=1 for exactly one cycle; go to IDLE.
- Latency, counted in rising edges from the edge that samples start to done visible:
  - Normal operation: 34 edges.
  - Special cases: 2 edges.
- Start while ready=0 is ignored; the in-flight operation and its operands are unaffected.
- Back-to-back: start may be asserted in the first IDLE cycle after DONE.
- Multiply:
  - Operands are converted to magnitudes according to signedness. MULH: both signed. MULHSU: A signed, B unsigned. MULHU/MUL: unsigned.
  - Unsigned 32x32 shift-add produces a 64-bit product.
  - FIX negates the product when exactly one signed operand is negative.
  - MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- Divide:
  - Restoring, magnitude-based.
  - Quotient is truncated toward zero; remainder takes the dividend's sign.
- Special cases, resolved in IDLE, bypassing CALC:
  - Divisor=0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → operandA.
  - Signed overflow, DIV with A=0x80000000 and B=0xFFFFFFFF: DIV → 0x80000000; REM → 0.
- All arithmetic is modulo 2^32 / 2^64. No exceptions or flags.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: multiply ops (funct3 0-3) use a single-cycle combinational 64-bit product and go IDLE→FIX→DONE, for 2-edge latency. Divide ops are unchanged.
- Undefined: all multiplies use the 32-iteration shift-add with 34-edge latency.
- Results are bit-identical either way.

Decomposition:
- Package muldiv_pkg:
  - XLEN constant.
  - funct3 encoding constants (MUL..REMU).
  - State enum: IDLE, CALC, FIX, DONE.
  - Helper predicates: is_div, is_signed_a, is_signed_b.
- One natural sub-module, muldiv_iter_core:
  - Holds the shared 64-bit accumulator/remainder register and the per-cycle shift-add or restoring-subtract step.
  - The top level keeps the FSM, special-case detection and sign fix.

Test Plan:
- MUL A=7, B=0xFFFFFFFD → result 0xFFFFFFEB. done after exactly 34 edges (2 with MULDIV_FAST_MUL_EN). ready=0 throughout.
- High-half products:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide: DIV 0xFFFFFFF9/2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Special cases, each with done after 2 edges:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
- Start pulsed at CALC counter=10 with different operands → ignored; original result delivered on schedule; exactly one done pulse.
- reset=1 for one cycle at counter=20 → next edge: IDLE, ready=1, result=0, no done. A fresh MUL 3×4 then returns 12.
